pio_shift_out: RTL and testbench

- Downstream consumer of the 8-bit LED/output PIO's out_port.
- Serialises the parallel PIO value into an external 74HC595-style shift/latch register chain using three wires: data, shift clock and latch.
- Transmits only on value change, on an explicit refresh request, or once after reset, so the CPU-side PIO never waits on serial timing.

---
 rtl/pio_shift_out_pkg.sv | 24 ++
 rtl/pio_shift_out_tick.sv | 30 +++
 rtl/pio_shift_out.sv | 124 ++++++++++++
 tb/tb_pio_shift_out.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_shift_out_pkg.sv
// Shared definitions for the PIO-to-74HC595 serialiser: FSM encoding and counter sizing.
package pio_shift_out_pkg;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SHIFT_LO = 2'd1;
    localparam logic [1:0] S_SHIFT_HI = 2'd2;
    localparam logic [1:0] S_LATCH    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = S_IDLE,
        ST_SHIFT_LO = S_SHIFT_LO,
        ST_SHIFT_HI = S_SHIFT_HI,
        ST_LATCH    = S_LATCH
    } state_t;

    // Ceiling log2, never below 1 so a counter for a count of 1 still has a bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/pio_shift_out_tick.sv
// Half-period divider: counts CLK_DIV enabled cycles and flags the last one.
module pio_shift_out_tick
    import pio_shift_out_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = clog2(CLK_DIV);

    logic [CW-1:0] count;

    assign last = enable && (count == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pio_shift_out.sv
// Serialises the PIO out_port into a 74HC595-style chain, sending a frame only on
// change, on a refresh request, or once after reset.
module pio_shift_out
    import pio_shift_out_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] par_in,
    input  logic              force_update,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_latch,
    output logic              busy,
    output logic [DATA_W-1:0] sent_value
);

    localparam int BW = clog2(DATA_W);

    state_t            state;
    logic              pend;
    logic              force_pend;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] capture_reg;
    logic [BW-1:0]     bit_idx;

    logic              start;
    logic              tick_last;
    logic [DATA_W-1:0] shifted;
    logic              first_bit;
    logic              next_bit;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted   = shift_reg << 1;
            assign first_bit = par_in[DATA_W-1];
            assign next_bit  = shifted[DATA_W-1];
        end else begin : g_lsb
            assign shifted   = shift_reg >> 1;
            assign first_bit = par_in[0];
            assign next_bit  = shifted[0];
        end
    endgenerate

    // sent_value is compared live, so a change made mid-frame is picked up in the next IDLE cycle.
    assign start = (state == ST_IDLE) && (pend || force_pend || (par_in != sent_value));

    pio_shift_out_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .enable  (state != ST_IDLE),
        .last    (tick_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pend        <= 1'b1;
            force_pend  <= 1'b0;
            shift_reg   <= '0;
            capture_reg <= '0;
            bit_idx     <= '0;
            ser_data    <= 1'b0;
            ser_clk     <= 1'b0;
            ser_latch   <= 1'b0;
            busy        <= 1'b0;
            sent_value  <= '0;
        end else begin
            if (force_update) force_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg   <= par_in;
                        capture_reg <= par_in;
                        pend        <= 1'b0;
                        force_pend  <= 1'b0;   // a coincident pulse is served by this frame
                        bit_idx     <= '0;
                        ser_data    <= first_bit;
                        ser_clk     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick_last) begin
                        ser_clk <= 1'b1;
                        state   <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick_last) begin
                        ser_clk <= 1'b0;
                        if (bit_idx == BW'(DATA_W - 1)) begin
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                            state     <= ST_LATCH;
                        end else begin
                            shift_reg <= shifted;
                            bit_idx   <= bit_idx + 1'b1;
                            ser_data  <= next_bit;
                            state     <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick_last) begin
                        ser_latch  <= 1'b0;
                        busy       <= 1'b0;
                        sent_value <= capture_reg;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_shift_out.sv
// Self-checking bench: a default instance and an LSB-first CLK_DIV=1 instance, frames decoded from the pins.
module tb_pio_shift_out;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] par0 = 8'h00, par1 = 8'h00;
    logic       force0 = 1'b0, force1 = 1'b0;
    logic       sd0, sc0, sl0, busy0;
    logic       sd1, sc1, sl1, busy1;
    logic [7:0] sv0, sv1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pio_shift_out #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) dut (
        .clk(clk), .reset_n(reset_n), .par_in(par0), .force_update(force0),
        .ser_data(sd0), .ser_clk(sc0), .ser_latch(sl0), .busy(busy0), .sent_value(sv0)
    );

    pio_shift_out #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .par_in(par1), .force_update(force1),
        .ser_data(sd1), .ser_clk(sc1), .ser_latch(sl1), .busy(busy1), .sent_value(sv1)
    );

    // Order in which the wire should carry the bits, first bit at [7].
    function automatic logic [7:0] exp_seq(input logic [7:0] v, input bit msb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = msb ? v[7-i] : v[i];
        return r;
    endfunction

    function automatic int frame_len(input int div);
        return 2 * div * 8 + div;
    endfunction

    task automatic sample(input int sel, output logic d, output logic c, output logic l,
                          output logic b, output logic [7:0] sv);
        if (sel == 0) begin d = sd0; c = sc0; l = sl0; b = busy0; sv = sv0; end
        else          begin d = sd1; c = sc1; l = sl1; b = busy1; sv = sv1; end
    endtask

    // Waits (bounded) for busy, then decodes one frame from the serial pins.
    task automatic capture_frame(input int sel, input int max_wait,
                                 output logic timed_out, output int waited,
                                 output logic [7:0] seq, output int busy_len,
                                 output int rises, output int toggles, output int latch_len,
                                 output int bad_level, output logic [7:0] sv_start,
                                 output logic [7:0] sv_end);
        logic d, c, l, b, pc, pd;
        logic [7:0] sv;
        timed_out = 1'b0; waited = 0; seq = '0; busy_len = 0; rises = 0; toggles = 0;
        latch_len = 0; bad_level = 0; sv_start = '0; sv_end = '0;
        b = 1'b0; d = 1'b0; c = 1'b0; l = 1'b0; sv = '0;
        while (!b && waited < max_wait) begin
            @(negedge clk);
            sample(sel, d, c, l, b, sv);
            if (!b) waited++;
        end
        if (!b) begin
            timed_out = 1'b1;
            $display("sel=%0d no frame within %0d cycles", sel, max_wait);
            return;
        end
        sv_start = sv;
        pc = 1'b0;
        pd = d;
        while (b && busy_len < 1000) begin
            busy_len++;
            if (c && !pc) begin rises++; seq = {seq[6:0], d}; end
            if (c != pc) toggles++;
            if (c && pc && d != pd) bad_level++;
            if (l) begin latch_len++; if (d || c) bad_level++; end
            pc = c;
            pd = d;
            @(negedge clk);
            sample(sel, d, c, l, b, sv);
        end
        if (d || c || l) bad_level++;
        sv_end = sv;
        $display("frame sel=%0d wait=%0d seq=%02h len=%0d rises=%0d latch=%0d sent=%02h",
                 sel, waited, seq, busy_len, rises, latch_len, sv_end);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({sd0, sc0, sl0, busy0, sv0} !== 12'h000) begin
            bad++; $display("FAIL reset_dut0: got %03h want 000", {sd0, sc0, sl0, busy0, sv0});
        end
        total++;
        if ({sd1, sc1, sl1, busy1, sv1} !== 12'h000) begin
            bad++; $display("FAIL reset_dut1: got %03h want 000", {sd1, sc1, sl1, busy1, sv1});
        end
    endtask

    task automatic test_startup();
        logic to0, to1; int w0, w1, bl0, bl1, r0, r1, t0, t1, ll0, ll1, bv0, bv1;
        logic [7:0] s0, s1, a0, a1, e0, e1;
        int busy_seen;
        reset_n = 1'b1;
        fork
            capture_frame(0, 5, to0, w0, s0, bl0, r0, t0, ll0, bv0, a0, e0);
            capture_frame(1, 5, to1, w1, s1, bl1, r1, t1, ll1, bv1, a1, e1);
        join
        total++;
        if (to0 !== 1'b0 || w0 != 0) begin bad++; $display("FAIL startup_start: timeout=%0b wait=%0d want 0/0", to0, w0); end
        total++;
        if (bl0 != frame_len(4)) begin bad++; $display("FAIL startup_len: got %0d want %0d", bl0, frame_len(4)); end
        total++;
        if (r0 != 8 || s0 !== 8'h00) begin bad++; $display("FAIL startup_bits: rises=%0d seq=%02h want 8/00", r0, s0); end
        total++;
        if (ll0 != 4 || bv0 != 0) begin bad++; $display("FAIL startup_latch: latch=%0d badlvl=%0d want 4/0", ll0, bv0); end
        total++;
        if (e0 !== 8'h00) begin bad++; $display("FAIL startup_sent: got %02h want 00", e0); end
        total++;
        if (to1 !== 1'b0 || bl1 != frame_len(1)) begin bad++; $display("FAIL startup_dut1_len: got %0d want %0d", bl1, frame_len(1)); end
        busy_seen = 0;
        repeat (20) begin @(negedge clk); if (busy0) busy_seen++; end
        total++;
        if (busy_seen != 0) begin bad++; $display("FAIL startup_idle: busy cycles %0d want 0", busy_seen); end
    endtask

    task automatic test_single_update();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e;
        par0 = 8'hA5;
        capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b0 || w != 0) begin bad++; $display("FAIL update_start: timeout=%0b wait=%0d want 0/0", to, w); end
        total++;
        if (s !== exp_seq(8'hA5, 1'b1) || r != 8) begin bad++; $display("FAIL update_bits: got %02h want %02h", s, exp_seq(8'hA5, 1'b1)); end
        total++;
        if (a !== 8'h00 || e !== 8'hA5) begin bad++; $display("FAIL update_sent: during=%02h after=%02h want 00/a5", a, e); end
        total++;
        if (bv != 0 || bl != frame_len(4)) begin bad++; $display("FAIL update_shape: badlvl=%0d len=%0d want 0/%0d", bv, bl, frame_len(4)); end
    endtask

    task automatic test_lsb_div1();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e;
        par1 = 8'h01;
        capture_frame(1, 5, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b0 || s !== exp_seq(8'h01, 1'b0)) begin bad++; $display("FAIL lsb_bits: got %02h want %02h", s, exp_seq(8'h01, 1'b0)); end
        total++;
        if (bl != 17 || t != 16) begin bad++; $display("FAIL lsb_timing: len=%0d toggles=%0d want 17/16", bl, t); end
        total++;
        if (ll != 1 || e !== 8'h01 || bv != 0) begin bad++; $display("FAIL lsb_latch: latch=%0d sent=%02h badlvl=%0d want 1/01/0", ll, e, bv); end
    endtask

    task automatic test_mid_frame();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e;
        par0 = 8'h0F;
        fork
            capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
            begin repeat (10) @(negedge clk); par0 = 8'hF0; end
        join
        total++;
        if (to !== 1'b0 || s !== 8'h0F || e !== 8'h0F) begin bad++; $display("FAIL mid_first: seq=%02h sent=%02h want 0f/0f", s, e); end
        capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b0 || w != 0) begin bad++; $display("FAIL mid_gap: timeout=%0b wait=%0d want 0/0", to, w); end
        total++;
        if (s !== 8'hF0 || e !== 8'hF0) begin bad++; $display("FAIL mid_second: seq=%02h sent=%02h want f0/f0", s, e); end
    endtask

    task automatic test_force();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e;
        @(negedge clk); force0 = 1'b1;
        @(negedge clk); force0 = 1'b0;
        fork
            capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
            for (int p = 0; p < 3; p++) begin
                repeat (8) @(negedge clk);
                force0 = 1'b1;
                @(negedge clk);
                force0 = 1'b0;
            end
        join
        total++;
        if (to !== 1'b0 || w != 0 || s !== 8'hF0) begin bad++; $display("FAIL force_first: timeout=%0b wait=%0d seq=%02h want 0/0/f0", to, w, s); end
        capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b0 || w != 0 || s !== 8'hF0 || bl != frame_len(4)) begin
            bad++; $display("FAIL force_retx: timeout=%0b wait=%0d seq=%02h len=%0d want 0/0/f0/%0d", to, w, s, bl, frame_len(4));
        end
        capture_frame(0, 150, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b1) begin bad++; $display("FAIL force_collapse: extra frame seq=%02h want none", s); end
    endtask

    task automatic test_revert();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e;
        par0 = 8'h33;
        fork
            capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
            begin
                repeat (10) @(negedge clk); par0 = 8'h44;
                repeat (20) @(negedge clk); par0 = 8'h33;
            end
        join
        total++;
        if (to !== 1'b0 || s !== 8'h33 || e !== 8'h33) begin bad++; $display("FAIL revert_frame: seq=%02h sent=%02h want 33/33", s, e); end
        capture_frame(0, 150, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b1) begin bad++; $display("FAIL revert_noframe: extra frame seq=%02h want none", s); end
    endtask

    task automatic test_reset_mid_frame();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e;
        par0 = 8'hFF;
        repeat (30) @(negedge clk);
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL rstmid_inframe: busy=%0b want 1", busy0); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({sd0, sc0, sl0, busy0, sv0} !== 12'h000) begin
            bad++; $display("FAIL rstmid_outputs: got %03h want 000", {sd0, sc0, sl0, busy0, sv0});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        capture_frame(0, 5, to, w, s, bl, r, t, ll, bv, a, e);
        total++;
        if (to !== 1'b0 || w != 0 || bl != frame_len(4)) begin bad++; $display("FAIL rstmid_frame: timeout=%0b wait=%0d len=%0d want 0/0/%0d", to, w, bl, frame_len(4)); end
        total++;
        if (s !== 8'hFF || a !== 8'h00 || e !== 8'hFF) begin bad++; $display("FAIL rstmid_value: seq=%02h before=%02h after=%02h want ff/00/ff", s, a, e); end
    endtask

    task automatic test_random();
        logic to; int w, bl, r, t, ll, bv; logic [7:0] s, a, e, v, prev;
        int sel;
        bit msb;
        for (int it = 0; it < 16; it++) begin
            sel = it % 2;
            msb = (sel == 0);
            v = 8'($urandom_range(0, 255));
            prev = (sel == 0) ? sv0 : sv1;
            if (sel == 0) par0 = v; else par1 = v;
            if (v == prev) begin
                if (sel == 0) force0 = 1'b1; else force1 = 1'b1;
                @(negedge clk);
                force0 = 1'b0; force1 = 1'b0;
            end
            capture_frame(sel, 5, to, w, s, bl, r, t, ll, bv, a, e);
            total++;
            if (to !== 1'b0 || w != 0 || s !== exp_seq(v, msb) || e !== v) begin
                bad++; $display("FAIL random_%0d: sel=%0d seq=%02h sent=%02h want %02h/%02h", it, sel, s, e, exp_seq(v, msb), v);
            end
            total++;
            if (bl != frame_len(msb ? 4 : 1) || bv != 0 || r != 8) begin
                bad++; $display("FAIL random_shape_%0d: len=%0d badlvl=%0d rises=%0d want %0d/0/8", it, bl, bv, r, frame_len(msb ? 4 : 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_single_update();
        test_lsb_div1();
        test_mid_frame();
        test_force();
        test_revert();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
